spike_aer_encoder: RTL

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

---
 rtl/spike_aer_encoder.sv | 91 +++++++++
 1 files changed

// File: rtl/spike_aer_encoder.sv
// Serialises one timestep's spike vector into address-event packets, lowest
// neuron index first, over a valid/ready handshake toward the synapse side.
module spike_aer_encoder #(
  parameter  int N     = 16,
  parameter  int LAYER = 0,
  parameter  int LW    = 8,
  localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [N-1:0]  spike_out,
  output logic          aer_valid,
  input  logic          aer_ready,
  output logic [LW-1:0] aer_layer,
  output logic [IW-1:0] aer_index,
  output logic          aer_last,
  output logic          done,
  output logic          busy,
  output logic [7:0]    overrun_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t        r_state;
  state_t        w_nextState;
  logic [N-1:0]  r_pend;
  logic [N-1:0]  w_lowBit;
  logic [IW-1:0] w_index;
  logic          w_last;
  logic          w_fire;
  logic          w_tickIdle;
  logic          r_done;
  logic [7:0]    r_ovr;

  // Two's-complement trick isolates the lowest pending spike; a single
  // remaining bit means the current event closes the timestep.
  assign w_lowBit   = r_pend & (~r_pend + ONE);
  assign w_last     = (r_pend != '0) && ((r_pend & (r_pend - ONE)) == '0);
  assign w_fire     = aer_valid && aer_ready;
  assign w_tickIdle = tick && (r_state == IDLE);

  always_comb begin
    w_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pend[i]) w_index = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (tick && (spike_out != '0)) w_nextState = SEND;
      SEND:    if (aer_ready && w_last)       w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    aer_valid = (r_state == SEND);
    busy      = (r_state == SEND);
    aer_index = (r_state == SEND) ? w_index : '0;
    aer_last  = (r_state == SEND) && w_last;
  end

  // Ticks arriving while a timestep is still draining are dropped, not queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_done <= 1'b0;
      r_ovr  <= '0;
    end else begin
      r_done <= (w_tickIdle && (spike_out == '0)) || (w_fire && w_last);
      if (w_tickIdle)  r_pend <= spike_out;
      else if (w_fire) r_pend <= r_pend & ~w_lowBit;
      if (tick && (r_state == SEND) && (r_ovr != 8'hFF)) r_ovr <= r_ovr + 8'd1;
    end
  end

  assign aer_layer   = LW'(LAYER);
  assign done        = r_done;
  assign overrun_cnt = r_ovr;

endmodule
